// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the two-digit display scheduler:
// segment patterns, FSM states and the display range limit.
package display_scheduler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  localparam logic [6:0] MAX_DISPLAY = 7'd99;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] clamp_value(
    input logic [6:0] v
  );
    return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Load/blink request bus from score logic and the
// status/segment outputs returned by the scheduler.
interface display_scheduler_if;
  logic       i_Load;
  logic [6:0] i_Value;
  logic       i_Blink;
  logic       o_Busy;
  logic       o_Clamp;
  logic [6:0] o_Segment1;
  logic [6:0] o_Segment2;

  modport slave (
    input  i_Load,
    input  i_Value,
    input  i_Blink,
    output o_Busy,
    output o_Clamp,
    output o_Segment1,
    output o_Segment2
  );

  modport master (
    output i_Load,
    output i_Value,
    output i_Blink,
    input  o_Busy,
    input  o_Clamp,
    input  o_Segment1,
    input  o_Segment2
  );
endinterface

// File: rtl/display_scheduler_digit_to_segment.sv
// BCD digit to active-low 7-segment pattern.
// Non-decimal codes fall back to the '0' pattern.
module digit_to_segment
  import display_scheduler_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup, no state
  always_comb begin
    seg_o = SEG_0;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_0;
    endcase
  end

endmodule

// File: rtl/display_scheduler.sv
// Splits a 0..99 value into tens/ones by repeated subtraction,
// commits both digits at once, then blanks/blinks the outputs.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int CLKS_PER_BLINK = 12500000,
  parameter bit LEAD_BLANK     = 1'b1
) (
  input logic                i_Clk,
  input logic                i_Rst,
  display_scheduler_if.slave bus
);

  localparam int CW =
    (CLKS_PER_BLINK > 1) ? $clog2(CLKS_PER_BLINK) : 1;
  localparam logic [CW-1:0] BLINK_LAST =
    CW'(CLKS_PER_BLINK - 1);

  state_e        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          clamp_q, clamp_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    tens_seg;
  logic [6:0]    ones_seg;

  // State and datapath registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      clamp_q <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      clamp_q <= clamp_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Load capture, subtract-by-ten loop and atomic commit
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    clamp_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Load) begin
          rem_d   = clamp_value(bus.i_Value);
          cnt_d   = '0;
          clamp_d = (bus.i_Value > MAX_DISPLAY);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (rem_q >= 7'd10) begin
          rem_d = rem_q - 7'd10;
          cnt_d = cnt_q + 4'd1;
        end else begin
          tens_d  = cnt_q;
          ones_d  = rem_q[3:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink half-period counter; idles ON at zero when disabled
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!bus.i_Blink) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  digit_to_segment u_tens (
    .digit_i (tens_q),
    .seg_o   (tens_seg)
  );

  digit_to_segment u_ones (
    .digit_i (ones_q),
    .seg_o   (ones_seg)
  );

  // Output shaping: leading-zero blank, then blink gate
  always_comb begin
    bus.o_Segment1 = tens_seg;
    bus.o_Segment2 = ones_seg;
    if (LEAD_BLANK && (tens_q == 4'd0)) begin
      bus.o_Segment1 = SEG_BLANK;
    end
    if (!phase_q) begin
      bus.o_Segment1 = SEG_BLANK;
      bus.o_Segment2 = SEG_BLANK;
    end
  end

  assign bus.o_Busy  = (state_q == CONVERT);
  assign bus.o_Clamp = clamp_q;

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences a binary value (0..99) onto the board's two 7-segment digits.
- Accepts a load request and splits the value into tens/ones by repeated subtraction of 10, one step per clock.
- Commits both digits atomically to avoid torn displays.
- Adds leading-zero blanking and a blink mode for alert indication; sits between game/score logic and the digit pins.

Parameters:
- CLKS_PER_BLINK, 12500000, clocks per blink half-period (0.5 s at 25 MHz); minimum 1.
- LEAD_BLANK, 1, 1 = tens digit blanked when tens = 0; 0 = shows '0'.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Load  in  1  load request, sampled each rising edge
- i_Value  in  7  binary value to display
- i_Blink  in  1  1 = blink displayed digits
- o_Busy  out  1  conversion in progress; loads ignored
- o_Clamp  out  1  one-cycle pulse: loaded value exceeded 99
- o_Segment1  out  7  tens digit, active-low, bit order gfedcba
- o_Segment2  out  7  ones digit, active-low, bit order gfedcba

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst is asynchronous and active-high.
- Reset values:
  - State IDLE; o_Busy = 0; o_Clamp = 0.
  - Committed tens = 0 and ones = 0; blink phase ON; blink counter 0.
  - o_Segment1 = 7'b1111111 if LEAD_BLANK, else 7'b1000000. o_Segment2 = 7'b1000000.
- FSM IDLE:
  - On i_Load = 1, capture rem = min(i_Value, 99) and tens = 0, then go to CONVERT; o_Busy = 1 from the next cycle.
  - If i_Value > 99, o_Clamp = 1 for exactly the cycle after the load edge.
- FSM CONVERT, each edge:
  - If rem >= 10: rem -= 10, tens += 1.
  - Else: commit tens and ones = rem[3:0] to the display registers, return to IDLE, o_Busy = 0.
- Latency: display changes tens+1 clocks after the load edge. o_Busy is high for tens+1 cycles (1..10).
- i_Load while o_Busy = 1 is ignored and not queued. i_Load is accepted on the first cycle o_Busy = 0 after a commit.
- The previous display is held unchanged during CONVERT. No partial update is ever visible.
- Widths: rem is 7 bits; tens and ones are 4 bits. Tens never exceeds 9 because the value is clamped.
- Segments are decoded combinationally from the committed registers, adding no latency.
- Blink:
  - With i_Blink = 1, the counter runs 0..CLKS_PER_BLINK-1 and toggles the phase at wrap.
  - In the OFF phase both segment outputs are 7'b1111111.
  - With i_Blink = 0, the phase is forced ON and the counter is held at 0. Asserting i_Blink therefore always starts with a full ON half-period.
  - A commit does not disturb the blink phase.
- Reset mid-CONVERT: immediate return to reset values; the in-flight value is discarded.

Decomposition:
- Shared package holds:
  - Segment constants, active-low gfedcba: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, BLANK = 1111111.
  - FSM state encodings IDLE and CONVERT.
  - Constant MAX_DISPLAY = 99.
- One sub-module, digit_to_segment: 4-bit digit in, 7-bit pattern out. Values above 9 map to the '0' pattern. Instantiated twice.
- Blink counter and FSM stay in the top module.

Test Plan:
- Reset asserted with LEAD_BLANK=1 -> o_Segment1 = 1111111, o_Segment2 = 1000000, o_Busy = 0, o_Clamp = 0.
- Load 42 -> o_Busy high exactly 5 cycles, display unchanged until commit. Then o_Segment1 = 0011001, o_Segment2 = 0100100.
- Load 7 (LEAD_BLANK=1) -> o_Busy high 1 cycle; o_Segment1 = 1111111, o_Segment2 = 1111000. Repeat with LEAD_BLANK=0 -> o_Segment1 = 1000000.
- Load 120 -> o_Clamp high for one cycle, o_Busy high 10 cycles; display 0010000 / 0010000 ("99").
- Load 42, then load 15 on the third busy cycle -> second load ignored; display "42". Load 15 after o_Busy falls -> display 1111001 / 0010010.
- CLKS_PER_BLINK=4, display "42", i_Blink=1 -> digits ON 4 cycles, BLANK 4 cycles, repeating. Drop i_Blink mid-OFF -> ON the next cycle. Assert i_Rst mid-CONVERT of 85 -> reset values, o_Busy = 0 immediately.
